// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
// ------------------
// UART transmit frame controller. Accepts one parallel word per handshake
// and serialises it as: start bit (0), DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit (1). Clocked by the baud clock, so one
// clk cycle is one bit period.
//
// Ports:
//   clk         TX baud clock
//   rst         asynchronous reset, active high
//   p_data      parallel data word, sampled on the accept edge
//   data_valid  send request, honoured only while idle
//   par_en      1 = append parity bit, sampled on the accept edge
//   par_typ     0 = even, 1 = odd parity, sampled on the accept edge
//   tx_out      serial line, idles high (registered)
//   busy        high while a frame is on the line (registered)
//   tx_done     one-cycle pulse during the stop bit (registered)

module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q,   state_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_out_q,  tx_out_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    // Next-state and next-data logic. The line outputs are decoded from the
    // *next* state/data so they can be registered without adding a cycle of
    // latency: the start bit appears on the accept edge itself.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        unique case (state_q)
            IDLE: begin
                if (data_valid) begin
                    shift_d   = p_data;
                    par_en_d  = par_en;
                    par_bit_d = (^p_data) ^ par_typ;
                    cnt_d     = '0;
                    state_d   = START;
                end
            end
            START: state_d = DATA;
            DATA: begin
                // Shift only while leaving a data cycle, so on entry from
                // START bit 0 is still at the LSB.
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT)
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: state_d = STOP;
            STOP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_out_d = 1'b1;
        unique case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = par_bit_d;
            default: tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic          tx_out;
    logic          busy;
    logic          tx_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic tx;
        logic bsy;
        logic done;
    } line_t;

    line_t exp_q[$];

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Scoreboard producers: expected per-cycle line state for a frame.
    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pbit);
        logic [DW-1:0] v;
        v = d;
        exp_q.push_back('{1'b0, 1'b1, 1'b0});
        for (int i = 0; i < DW; i++) exp_q.push_back('{v[i], 1'b1, 1'b0});
        if (pe) exp_q.push_back('{pbit, 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 1'b1, 1'b1});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, 1'b0, 1'b0});
    endtask

    // Advance one bit period, sample just after the edge, pop the expectation.
    task automatic step(output line_t e, output line_t a);
        @(posedge clk);
        #1;
        a = '{tx_out, busy, tx_done};
        if (exp_q.size() == 0) e = '{1'b1, 1'b0, 1'b0};
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset;
        line_t e, a;
        rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
        #1;
        total_cnt++;
        if ({tx_out, busy, tx_done} !== 3'b100)
            $display("FAIL reset_async: got tx=%b busy=%b done=%b want tx=1 busy=0 done=0",
                     tx_out, busy, tx_done);
        else pass_cnt++;
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            data_valid = ~data_valid;
            p_data = 8'h55;
            step(e, a);
            total_cnt++;
            if (a !== e)
                $display("FAIL reset_hold c%0d: got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                         i, a.tx, a.bsy, a.done, e.tx, e.bsy, e.done);
            else pass_cnt++;
        end
        @(negedge clk);
        data_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_no_parity;
        line_t e, a;
        @(negedge clk);
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        push_frame(8'hA5, 1'b0, 1'b0);
        push_idle(2);
        for (int i = 0; i < 12; i++) begin
            step(e, a);
            if (i == 0) data_valid = 1'b0;
            total_cnt++;
            if (a !== e)
                $display("FAIL nopar c%0d: got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                         i, a.tx, a.bsy, a.done, e.tx, e.bsy, e.done);
            else pass_cnt++;
        end
    endtask

    task automatic test_parity;
        line_t e, a;
        logic [DW-1:0] dat [3] = '{8'hA5, 8'hA5, 8'h01};
        logic          typ [3] = '{1'b0, 1'b1, 1'b0};
        logic          pb  [3] = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            p_data = dat[t]; par_en = 1'b1; par_typ = typ[t]; data_valid = 1'b1;
            push_frame(dat[t], 1'b1, pb[t]);
            push_idle(1);
            for (int i = 0; i < 12; i++) begin
                step(e, a);
                if (i == 0) begin
                    data_valid = 1'b0;
                    p_data = ~dat[t];
                    par_typ = ~typ[t];
                end
                total_cnt++;
                if (a !== e)
                    $display("FAIL parity t%0d c%0d: got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                             t, i, a.tx, a.bsy, a.done, e.tx, e.bsy, e.done);
                else pass_cnt++;
            end
        end
    endtask

    // data_valid held high; inputs change mid-frame and must only affect
    // the following frame. Second frame uses even parity on 0xFF -> 0.
    task automatic test_back_to_back;
        line_t e, a;
        @(negedge clk);
        p_data = 8'h00; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        push_frame(8'h00, 1'b1, 1'b1);
        push_idle(1);
        push_frame(8'hFF, 1'b1, 1'b0);
        push_idle(2);
        for (int i = 0; i < 26; i++) begin
            step(e, a);
            if (i == 3) begin
                p_data = 8'hFF;
                par_typ = 1'b0;
            end
            if (i == 12) data_valid = 1'b0;
            total_cnt++;
            if (a !== e)
                $display("FAIL b2b c%0d: got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                         i, a.tx, a.bsy, a.done, e.tx, e.bsy, e.done);
            else pass_cnt++;
        end
    endtask

    task automatic test_valid_while_busy;
        line_t e, a;
        @(negedge clk);
        p_data = 8'h5A; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        push_frame(8'h5A, 1'b0, 1'b0);
        push_idle(3);
        for (int i = 0; i < 13; i++) begin
            step(e, a);
            if (i == 0) data_valid = 1'b0;
            if (i == 5) begin
                data_valid = 1'b1;
                p_data = 8'hFF;
                par_en = 1'b1;
            end
            if (i == 6) data_valid = 1'b0;
            total_cnt++;
            if (a !== e)
                $display("FAIL busy_ignore c%0d: got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                         i, a.tx, a.bsy, a.done, e.tx, e.bsy, e.done);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midframe;
        line_t e, a;
        @(negedge clk);
        p_data = 8'hC3; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        push_frame(8'hC3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(e, a);
            if (i == 0) data_valid = 1'b0;
            total_cnt++;
            if (a !== e)
                $display("FAIL rst_mid_pre c%0d: got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                         i, a.tx, a.bsy, a.done, e.tx, e.bsy, e.done);
            else pass_cnt++;
        end
        // Now inside data bit 3; abort between edges.
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({tx_out, busy, tx_done} !== 3'b100)
            $display("FAIL rst_mid_async: got tx=%b busy=%b done=%b want tx=1 busy=0 done=0",
                     tx_out, busy, tx_done);
        else pass_cnt++;
        exp_q.delete();
        // Release reset with data_valid already asserted in the same cycle.
        @(negedge clk);
        rst = 1'b0;
        p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        push_frame(8'h3C, 1'b1, 1'b0);
        push_idle(2);
        for (int i = 0; i < 13; i++) begin
            step(e, a);
            if (i == 0) data_valid = 1'b0;
            total_cnt++;
            if (a !== e)
                $display("FAIL rst_mid_post c%0d: got tx=%b busy=%b done=%b want tx=%b busy=%b done=%b",
                         i, a.tx, a.bsy, a.done, e.tx, e.bsy, e.done);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_no_parity;
        test_parity;
        test_back_to_back;
        test_valid_while_busy;
        test_reset_midframe;
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
